// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the add-3 adjustment constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;
    localparam logic [3:0] BCD_NINE   = 4'h9;

    // Bits needed to hold values 0..v-1, minimum 1.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: adds 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_d,
    output logic [3:0] o_d
);

    // Add-3 correction for digits that would exceed 9 after doubling.
    always_comb begin
        o_d = i_d;
        if (i_d >= ADJ_THRESH) begin
            o_d = i_d + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per clock.
// Result and overflow are registered and held between done pulses.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = clog2(IN_W + 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [IN_W-1:0] r_bin;
    logic [BW-1:0]   r_acc;
    logic            r_sticky;

    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_acc_nxt;
    logic [BW-1:0]   w_sat;
    logic            w_sticky_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_d (r_acc[4*g +: 4]),
            .o_d (w_adj[4*g +: 4])
        );
    end

    // Next accumulator after one adjust-and-shift step; the bit leaving
    // the top digit feeds the overflow sticky bit.
    always_comb begin
        w_acc_nxt    = {w_adj[BW-2:0], r_bin[IN_W-1]};
        w_sticky_nxt = r_sticky | w_adj[BW-1];
        w_sat        = {DIGITS{BCD_NINE}};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bin    <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_bin    <= bin;
                        r_acc    <= '0;
                        r_sticky <= 1'b0;
                        r_cnt    <= CW'(IN_W);
                        busy     <= 1'b1;
                        r_state  <= SHIFT;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                SHIFT: begin
                    r_acc    <= w_acc_nxt;
                    r_bin    <= r_bin << 1;
                    r_sticky <= w_sticky_nxt;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bcd     <= w_sticky_nxt ? w_sat : w_acc_nxt;
                        ovf     <= w_sticky_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: vector table, full sweep, and
// multi-cycle sequences (back-to-back, ignored start, async reset).
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy, done, ovf;
    logic [11:0] bcd;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        logic [7:0]  v;
        logic [11:0] b3;
        logic [7:0]  b2;
        logic        o2;
    } vec_t;

    vec_t tv[10];

    bin2bcd_seq #(.IN_W(8), .DIGITS(3)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    bin2bcd_seq #(.IN_W(8), .DIGITS(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy2),
        .done  (done2),
        .bcd   (bcd2),
        .ovf   (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] ref3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] ref2(input int v);
        if (v > 99) return 8'h99;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Pulse start with v, wait for done; c is the cycle of done.
    task automatic run(input logic [7:0] v, output int c, output bit bok);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        c     = 1;
        bok   = 1'b1;
        while (!done && c < 30) begin
            if (!busy || done2) bok = 1'b0;
            tick();
            c++;
        end
    endtask

    int c;
    bit bok;
    bit seen;

    initial begin
        tv[0] = '{8'd37,  12'h037, 8'h37, 1'b0};
        tv[1] = '{8'd0,   12'h000, 8'h00, 1'b0};
        tv[2] = '{8'd255, 12'h255, 8'h99, 1'b1};
        tv[3] = '{8'd99,  12'h099, 8'h99, 1'b0};
        tv[4] = '{8'd100, 12'h100, 8'h99, 1'b1};
        tv[5] = '{8'd42,  12'h042, 8'h42, 1'b0};
        tv[6] = '{8'd200, 12'h200, 8'h99, 1'b1};
        tv[7] = '{8'd9,   12'h009, 8'h09, 1'b0};
        tv[8] = '{8'd10,  12'h010, 8'h10, 1'b0};
        tv[9] = '{8'd128, 12'h128, 8'h99, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        bin   = 8'd0;
        #12;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_bcd", {20'd0, bcd}, 0);
        chk("reset_ovf", {31'd0, ovf}, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run(tv[i].v, c, bok);
            chk($sformatf("lat_%0d", tv[i].v), c, 9);
            chk($sformatf("busy_win_%0d", tv[i].v), {31'd0, bok}, 1);
            chk($sformatf("busy_at_done_%0d", tv[i].v), {31'd0, busy}, 0);
            chk($sformatf("bcd3_%0d", tv[i].v), {20'd0, bcd}, {20'd0, tv[i].b3});
            chk($sformatf("ovf3_%0d", tv[i].v), {31'd0, ovf}, 0);
            chk($sformatf("bcd2_%0d", tv[i].v), {24'd0, bcd2}, {24'd0, tv[i].b2});
            chk($sformatf("ovf2_%0d", tv[i].v), {31'd0, ovf2}, {31'd0, tv[i].o2});
            tick();
            chk($sformatf("done_pulse_%0d", tv[i].v), {31'd0, done}, 0);
            chk($sformatf("bcd_hold_%0d", tv[i].v), {20'd0, bcd}, {20'd0, tv[i].b3});
        end

        for (int v = 0; v < 256; v++) begin
            run(8'(v), c, bok);
            chk($sformatf("sweep_lat_%0d", v), c, 9);
            chk($sformatf("sweep_bcd3_%0d", v), {20'd0, bcd}, {20'd0, ref3(v)});
            chk($sformatf("sweep_bcd2_%0d", v), {24'd0, bcd2}, {24'd0, ref2(v)});
            chk($sformatf("sweep_ovf2_%0d", v), {31'd0, ovf2}, {31'd0, v > 99});
        end
        tick();

        // Back-to-back: start held high, 99 then 100.
        bin   = 8'd99;
        start = 1'b1;
        tick();
        bin   = 8'd100;
        c     = 1;
        while (!done && c < 30) begin
            tick();
            c++;
        end
        chk("b2b_first_done", c, 9);
        chk("b2b_first_bcd", {20'd0, bcd}, 32'h099);
        tick();
        c++;
        chk("b2b_no_gap_busy", {31'd0, busy}, 1);
        chk("b2b_hold_bcd", {20'd0, bcd}, 32'h099);
        start = 1'b0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        chk("b2b_second_done", c, 18);
        chk("b2b_second_bcd", {20'd0, bcd}, 32'h100);
        chk("b2b_second_ovf2", {31'd0, ovf2}, 1);
        tick();

        // Start re-pulsed at cycles 3 and 5 while converting 42.
        bin   = 8'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        c     = 1;
        while (!done && c < 30) begin
            start = (c == 3 || c == 5);
            if (start) bin = 8'd77;
            tick();
            c++;
        end
        start = 1'b0;
        chk("ignore_done_cycle", c, 9);
        chk("ignore_bcd", {20'd0, bcd}, 32'h042);
        tick();
        chk("ignore_not_queued", {31'd0, busy}, 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk("ignore_single_done", {31'd0, seen}, 0);

        // Async reset at cycle 4 of converting 200.
        bin   = 8'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_bcd", {20'd0, bcd}, 0);
        chk("arst_ovf", {31'd0, ovf}, 0);
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        chk("arst_no_done", {31'd0, seen}, 0);
        run(8'd200, c, bok);
        chk("arst_restart_lat", c, 9);
        chk("arst_restart_bcd", {20'd0, bcd}, 32'h200);
        chk("arst_restart_ovf2", {31'd0, ovf2}, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
